// File: rtl/dht11_poll_sched.sv
`default_nettype none
// ============================================================================
// Module   : dht11_poll_sched
// Brief    : Periodic DHT11 read scheduler with timeout, checksum check,
//            retry-with-gap and req/ack hand-off to the display driver.
// Revision : 1.0
// ============================================================================
module dht11_poll_sched #(
    parameter int unsigned MS_CYCLES  = 100_000,
    parameter int unsigned PERIOD_MS  = 2000,
    parameter int unsigned TIMEOUT_MS = 30,
    parameter int unsigned RETRY_MS   = 1100,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        rd_err,
    input  logic [39:0] rd_frame,
    output logic        disp_req,
    input  logic        disp_ack,
    output logic [7:0]  disp_hum,
    output logic [7:0]  disp_temp,
    output logic        disp_err,
    output logic [7:0]  hum,
    output logic [7:0]  temp,
    output logic        valid,
    output logic [7:0]  fail_cnt,
    output logic        busy
);
    localparam logic [31:0] C_PERIOD_LAST  = 32'(PERIOD_MS * MS_CYCLES - 1);
    localparam logic [31:0] C_TIMEOUT_LAST = 32'(TIMEOUT_MS * MS_CYCLES - 1);
    localparam logic [31:0] C_RETRY_LAST   = 32'(RETRY_MS * MS_CYCLES - 1);
    localparam logic [7:0]  C_MAX_RETRY    = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_GAP   = 3'd4,
        S_DISP  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [39:0] frame_q, frame_d;
    logic [7:0]  hum_q, hum_d, temp_q, temp_d;
    logic [7:0]  disp_hum_q, disp_hum_d, disp_temp_q, disp_temp_d;
    logic        disp_err_q, disp_err_d, valid_q, valid_d;
    logic [7:0]  fail_cnt_q, fail_cnt_d;
    logic        rd_start_q, rd_start_d, disp_req_q, disp_req_d, busy_q, busy_d;
    logic        fail_ev;
    logic [7:0]  w_sum, w_retry_inc;

    assign w_sum       = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign w_retry_inc = retry_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        frame_d     = frame_q;
        hum_d       = hum_q;
        temp_d      = temp_q;
        disp_hum_d  = disp_hum_q;
        disp_temp_d = disp_temp_q;
        disp_err_d  = disp_err_q;
        valid_d     = valid_q;
        fail_cnt_d  = fail_cnt_q;
        fail_ev     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!en) begin
                    cnt_d = '0;
                end else if (cnt_q >= C_PERIOD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_err) begin
                    fail_ev = 1'b1;
                end else if (rd_done) begin
                    frame_d = rd_frame;
                    state_d = S_CHECK;
                end else if (cnt_q >= C_TIMEOUT_LAST) begin
                    fail_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CHECK: begin
                if (w_sum == frame_q[7:0]) begin
                    hum_d       = frame_q[39:32];
                    temp_d      = frame_q[23:16];
                    disp_hum_d  = frame_q[39:32];
                    disp_temp_d = frame_q[23:16];
                    disp_err_d  = 1'b0;
                    valid_d     = 1'b1;
                    retry_d     = '0;
                    state_d     = S_DISP;
                end else begin
                    fail_ev = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q >= C_RETRY_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DISP: begin
                if (disp_ack) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The failing cycle itself counts as the first cycle of the retry gap.
        if (fail_ev) begin
            fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
            if (w_retry_inc < C_MAX_RETRY) begin
                retry_d = w_retry_inc;
                cnt_d   = 32'd1;
                state_d = S_GAP;
            end else begin
                retry_d    = '0;
                valid_d    = 1'b0;
                disp_err_d = 1'b1;
                state_d    = S_DISP;
            end
        end

        rd_start_d = (state_d == S_START);
        disp_req_d = (state_d == S_DISP);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            frame_q     <= '0;
            hum_q       <= '0;
            temp_q      <= '0;
            disp_hum_q  <= '0;
            disp_temp_q <= '0;
            disp_err_q  <= 1'b0;
            valid_q     <= 1'b0;
            fail_cnt_q  <= '0;
            rd_start_q  <= 1'b0;
            disp_req_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            frame_q     <= frame_d;
            hum_q       <= hum_d;
            temp_q      <= temp_d;
            disp_hum_q  <= disp_hum_d;
            disp_temp_q <= disp_temp_d;
            disp_err_q  <= disp_err_d;
            valid_q     <= valid_d;
            fail_cnt_q  <= fail_cnt_d;
            rd_start_q  <= rd_start_d;
            disp_req_q  <= disp_req_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_start  = rd_start_q;
    assign disp_req  = disp_req_q;
    assign disp_hum  = disp_hum_q;
    assign disp_temp = disp_temp_q;
    assign disp_err  = disp_err_q;
    assign hum       = hum_q;
    assign temp      = temp_q;
    assign valid     = valid_q;
    assign fail_cnt  = fail_cnt_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_poll_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_poll_sched
// Brief    : Directed self-checking bench for dht11_poll_sched with a
//            transaction-level expectation model and a per-cycle comparator.
// Revision : 1.0
// ============================================================================
module tb_dht11_poll_sched;
    localparam int MS = 10, PER = 5, TO = 3, RT = 2, MR = 3;
    localparam int K_DONE = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic        rd_done = 1'b0, rd_err = 1'b0, disp_ack = 1'b0;
    logic [39:0] rd_frame = '0;
    logic        rd_start, disp_req, disp_err, valid, busy;
    logic [7:0]  disp_hum, disp_temp, hum, temp, fail_cnt;

    dht11_poll_sched #(
        .MS_CYCLES(MS), .PERIOD_MS(PER), .TIMEOUT_MS(TO), .RETRY_MS(RT), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rd_start(rd_start), .rd_done(rd_done),
        .rd_err(rd_err), .rd_frame(rd_frame), .disp_req(disp_req), .disp_ack(disp_ack),
        .disp_hum(disp_hum), .disp_temp(disp_temp), .disp_err(disp_err), .hum(hum),
        .temp(temp), .valid(valid), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0, nfail = 0, cyc = 0;
    bit chk_en = 1'b0;
    // Expected observable state; m_next_start is the cycle rd_start must pulse.
    int m_hum = 0, m_temp = 0, m_valid = 0, m_fail = 0, m_retry = 0;
    int m_dreq = 0, m_dhum = 0, m_dtemp = 0, m_derr = 0, m_busy = 0;
    int m_next_start = -1;
    int first_start = -1, last_start = -1, prev_start = -1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_start", rd_start, (cyc == m_next_start) ? 1 : 0);
            chk("disp_req", disp_req, m_dreq);
            chk("disp_hum", disp_hum, m_dhum);
            chk("disp_temp", disp_temp, m_dtemp);
            chk("disp_err", disp_err, m_derr);
            chk("hum", hum, m_hum);
            chk("temp", temp, m_temp);
            chk("valid", valid, m_valid);
            chk("fail_cnt", fail_cnt, m_fail);
            chk("busy", busy, m_busy);
        end
        if (rd_start === 1'b1) begin
            if (first_start < 0) first_start = cyc;
            prev_start = last_start;
            last_start = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rd_done  = 1'b0;
        rd_err   = 1'b0;
        disp_ack = 1'b0;
        if (cyc == m_next_start) m_busy = 1;
    endtask

    task automatic tick_until(input int c);
        if (c < cyc || c - cyc > 3000) chk("tick_until_bound", cyc, c);
        else while (cyc < c) tick();
    endtask

    function automatic bit csum_ok(input logic [39:0] fr);
        int s;
        s = int'(fr[39:32]) + int'(fr[31:24]) + int'(fr[23:16]) + int'(fr[15:8]);
        return (s % 256) == int'(fr[7:0]);
    endfunction

    task automatic model_good(input logic [39:0] fr);
        m_hum = int'(fr[39:32]); m_temp = int'(fr[23:16]); m_valid = 1; m_retry = 0;
        m_dhum = m_hum; m_dtemp = m_temp; m_derr = 0; m_dreq = 1;
    endtask

    // f is the cycle the failure was decided; the retry gap is measured from it.
    task automatic model_fail(input int f);
        if (m_fail < 255) m_fail++;
        m_retry++;
        if (m_retry < MR) m_next_start = f + RT * MS;
        else begin
            m_retry = 0; m_valid = 0; m_derr = 1; m_dreq = 1;
        end
    endtask

    task automatic model_reset();
        m_hum = 0; m_temp = 0; m_valid = 0; m_fail = 0; m_retry = 0;
        m_dreq = 0; m_dhum = 0; m_dtemp = 0; m_derr = 0; m_busy = 0; m_next_start = -1;
    endtask

    task automatic do_read(input int kind, input logic [39:0] fr, input int dly,
                           output int s, output int f);
        tick_until(m_next_start);
        s = cyc;
        f = -1;
        if (kind == K_NONE) begin
            f = s + TO * MS;
            tick_until(f + 1);
            model_fail(f);
        end else begin
            tick_until(s + dly);
            rd_frame = fr;
            rd_done  = (kind != K_ERR);
            rd_err   = (kind != K_DONE);
            if (kind == K_DONE && csum_ok(fr)) begin
                tick_until(s + dly + 2);
                model_good(fr);
            end else begin
                f = (kind == K_DONE) ? s + dly + 1 : s + dly;
                tick_until(f + 1);
                model_fail(f);
            end
        end
    endtask

    // Ack k cycles after the call; returns the cycle disp_req is expected low.
    task automatic ack_after(input int k, output int drop);
        tick_until(cyc + k);
        disp_ack = 1'b1;
        tick();
        drop = cyc;
        m_dreq = 0; m_busy = 0;
        m_next_start = en ? cyc + PER * MS : -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] f_good, f_bad, f_two, f_both;
        int s, f, d, a;
        f_good = {8'd52, 8'd0, 8'd24, 8'd0, 8'd76};
        f_bad  = {8'd52, 8'd0, 8'd24, 8'd0, 8'd77};
        f_two  = {8'd60, 8'd0, 8'd21, 8'd0, 8'd81};
        f_both = {8'd70, 8'd0, 8'd30, 8'd0, 8'd100};

        repeat (3) tick();
        chk_en = 1'b1;
        repeat (3) tick();
        cyc = 0; rst = 1'b1; en = 1'b1;
        m_next_start = PER * MS;

        // Good read, then ignored strobes while idle
        do_read(K_DONE, f_good, 3, s, f);
        chk("first_start_lit", first_start, 50);
        chk("hum_lit", hum, 52);
        chk("temp_lit", temp, 24);
        chk("disp_hum_lit", disp_hum, 52);
        chk("valid_lit", valid, 1);
        ack_after(4, d);
        chk("busy_after_ack_lit", busy, 0);
        tick();
        rd_frame = 40'hFF_FF_FF_FF_FC; rd_done = 1'b1; rd_err = 1'b1; disp_ack = 1'b1;
        tick();

        // Bad checksum, retry after the gap
        do_read(K_DONE, f_bad, 2, s, f);
        chk("fail_cnt_lit1", fail_cnt, 1);
        chk("no_disp_req_lit", disp_req, 0);
        do_read(K_DONE, f_good, 5, s, a);
        chk("retry_gap_lit", last_start - f, 20);
        ack_after(2, d);

        // Three timeouts exhaust the retries
        do_read(K_NONE, '0, 0, s, f);
        do_read(K_NONE, '0, 0, s, f);
        chk("timeout_spacing_lit", last_start - prev_start, 50);
        do_read(K_NONE, '0, 0, s, f);
        chk("fail_cnt_lit4", fail_cnt, 4);
        chk("disp_err_lit", disp_err, 1);
        chk("valid_drop_lit", valid, 0);
        chk("hum_keep_lit", hum, 52);
        chk("temp_keep_lit", temp, 24);
        ack_after(3, d);

        // Display backpressure
        do_read(K_DONE, f_two, 4, s, f);
        ack_after(100, d);

        // Simultaneous done+err on a valid frame
        do_read(K_BOTH, f_both, 2, s, f);
        chk("post_ack_start_lit", last_start - d, 50);
        chk("hum_both_lit", hum, 60);
        chk("fail_cnt_lit5", fail_cnt, 5);

        // Reset while waiting on the reader, then hold off with en=0
        a = m_next_start;
        tick_until(a + 2);
        rst = 1'b0; en = 1'b0;
        model_reset();
        tick();
        chk("rst_fail_cnt_lit", fail_cnt, 0);
        chk("rst_busy_lit", busy, 0);
        tick();
        rst = 1'b1;
        repeat (500) tick();
        chk("no_start_en0_lit", last_start, a);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
`default_nettype wire
